// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage valid/ready register pipeline with bubble collapsing and synchronous flush.
// Define DFF_PIPE_OCC_EN to add the occ port (count of valid stages).
module dff_pipe #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // valid never waits for ready, and out_data is held while out_valid & ~out_ready.

    logic [DEPTH-1:0] v;
    logic [DW-1:0]    d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [DW-1:0]    up_d [DEPTH];

    // A stage is ready when it or any stage downstream of it is empty, or the sink takes data.
    always_comb begin
        logic acc;
        acc = out_ready;
        rdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~v[i];
            rdy[i] = acc;
        end
    end

    always_comb begin
        up_v    = '0;
        up_v[0] = in_valid & ~flush;
        up_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = d[i-1];
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= up_v[i];
                    if (up_v[i]) begin
                        d[i] <= up_d[i];
                    end
                end
            end
        end
    end

`ifdef DFF_PIPE_OCC_EN
    localparam int OW = $clog2(DEPTH + 1);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = v[DEPTH-1] & out_ready;

    // Tracks popcount(v) incrementally; flush and rst empty the pipe outright.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ <= '0;
        end else if (in_fire && !out_fire) begin
            occ <= occ + OW'(1);
        end else if (out_fire && !in_fire) begin
            occ <= occ - OW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: drives DEPTH=1..4 instances of dff_pipe with shared stimulus and checks each
// against a payload/position queue model of the pipeline.
module tb_dff_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    logic        in_ready_a  [4];
    logic        out_valid_a [4];
    logic [31:0] out_data_a  [4];
    logic [2:0]  occ_a       [4];

`ifdef DFF_PIPE_OCC_EN
    logic [0:0] occ1;
    logic [1:0] occ2;
    logic [1:0] occ3;
    logic [2:0] occ4;
    assign occ_a[0] = {2'b0, occ1};
    assign occ_a[1] = {1'b0, occ2};
    assign occ_a[2] = {1'b0, occ3};
    assign occ_a[3] = occ4;
`else
    assign occ_a[0] = '0;
    assign occ_a[1] = '0;
    assign occ_a[2] = '0;
    assign occ_a[3] = '0;
`endif

    dff_pipe #(.DW(32), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a[0]),
        .in_data(in_data), .out_valid(out_valid_a[0]), .out_ready(out_ready), .out_data(out_data_a[0])
`ifdef DFF_PIPE_OCC_EN
        , .occ(occ1)
`endif
    );

    dff_pipe #(.DW(32), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a[1]),
        .in_data(in_data), .out_valid(out_valid_a[1]), .out_ready(out_ready), .out_data(out_data_a[1])
`ifdef DFF_PIPE_OCC_EN
        , .occ(occ2)
`endif
    );

    dff_pipe #(.DW(32), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a[2]),
        .in_data(in_data), .out_valid(out_valid_a[2]), .out_ready(out_ready), .out_data(out_data_a[2])
`ifdef DFF_PIPE_OCC_EN
        , .occ(occ3)
`endif
    );

    dff_pipe #(.DW(32), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a[3]),
        .in_data(in_data), .out_valid(out_valid_a[3]), .out_ready(out_ready), .out_data(out_data_a[3])
`ifdef DFF_PIPE_OCC_EN
        , .occ(occ4)
`endif
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per instance, the payloads in flight (exp_q, oldest first) and the
    // stage index each one currently occupies.
    int          dep_a [4];
    int          pos_q [4][$];
    logic [31:0] exp_q [4][$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_dut(input int k, input logic ordy, input logic fl);
        int   dep;
        int   n;
        logic exp_ov;
        dep    = dep_a[k];
        n      = pos_q[k].size();
        exp_ov = (n > 0) && (pos_q[k][0] == dep - 1);
        check($sformatf("in_ready[D%0d]", dep), 64'(in_ready_a[k]), 64'(((n < dep) || ordy) && !fl));
        check($sformatf("out_valid[D%0d]", dep), 64'(out_valid_a[k]), 64'(exp_ov));
        if (exp_ov) begin
            check($sformatf("out_data[D%0d]", dep), 64'(out_data_a[k]), 64'(exp_q[k][0]));
        end
`ifdef DFF_PIPE_OCC_EN
        check($sformatf("occ[D%0d]", dep), 64'(occ_a[k]), 64'(n));
`endif
    endtask

    // Every payload advances one stage unless the stage it would enter stays occupied;
    // the oldest leaves past the last stage only when the sink is ready.
    task automatic model_update(input int k, input logic iv, input logic [31:0] id,
                                input logic ordy, input logic fl, input logic r);
        int   dep;
        int   ahead;
        logic accept;
        dep = dep_a[k];
        if (r) begin
            pos_q[k].delete();
            exp_q[k].delete();
            return;
        end
        accept = iv && !fl && ((pos_q[k].size() < dep) || ordy);
        ahead  = ordy ? dep + 1 : dep;
        for (int i = 0; i < pos_q[k].size(); i++) begin
            if (pos_q[k][i] + 1 < ahead) pos_q[k][i] = pos_q[k][i] + 1;
            ahead = pos_q[k][i];
        end
        if (pos_q[k].size() > 0 && pos_q[k][0] == dep) begin
            void'(pos_q[k].pop_front());
            void'(exp_q[k].pop_front());
        end
        if (accept) begin
            pos_q[k].push_back(0);
            exp_q[k].push_back(id);
        end
        if (fl) begin
            pos_q[k].delete();
            exp_q[k].delete();
        end
    endtask

    // Driver: apply one cycle of inputs, check all instances, then advance the model and clock.
    task automatic step(input logic iv, input logic [31:0] id, input logic ordy,
                        input logic fl, input logic r);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (!r) compare_dut(k, ordy, fl);
            model_update(k, iv, id, ordy, fl, r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        dep_a     = '{1, 2, 3, 4};
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        @(posedge clk);
        #1;

        // Reset with in_valid held high: nothing captured, data registers cleared.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_out_data[D%0d]", dep_a[k]), 64'(out_data_a[k]), 64'd0);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Streaming 1..8 with out_ready high.
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Back-pressure: 0xA, 0xB then stall five cycles, then drain.
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Bubble collapse: one payload slides to the end, then fill until in_ready drops.
        do_reset();
        step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h60 + 32'(i), 1'b0, 1'b0, 1'b0);

        // Flush while full with in_valid high; the input payload must not be captured.
        step(1'b1, 32'h77, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush coinciding with an output handshake.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h80 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 10000; c++) begin
            step(1'($urandom_range(0, 1)), $urandom(),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 499) == 0));
        end

        // Drain
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
